heap_op_scheduler: RTL

//  Shares one heap_module instance between NREQ requesters. Round-robin arbitration of push/pop

---
 rtl/heap_op_scheduler.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/heap_op_scheduler.sv
// ============================================================================
// heap_op_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//   Shares a single heap_module between NREQ requesters. Push/pop requests are
//   arbitrated round-robin. The winning request either drives one heap command
//   and waits for the heap to settle, or it is rejected straight away. A request
//   is rejected when it is a push to a full heap or a pop from an empty heap.
//   The scheduler keeps its own occupancy count so that it can reject requests
//   without asking the heap. Every accepted request gets exactly one response
//   strobe on the shared response bus.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        asynchronous, active-high reset
//   req_valid    per-requester request pending
//   req_op       per-requester operation, 0 = push, 1 = pop
//   req_data     per-requester push value, requester k at [k*DW +: DW]
//   req_ready    one-hot grant (only while idle)
//   rsp_valid    one-cycle response strobe
//   rsp_id       index of the requester being answered
//   rsp_data     popped value on a good pop, otherwise 0
//   rsp_err      push when full / pop when empty
//   heap_enable  heap command strobe (heap_module.enable)
//   heap_op      heap command, INIT=0 PUSH=1 POP=2 (heap_module.operation)
//   heap_din     heap push value (heap_module.input_value)
//   heap_top     heap_module.heap_array[0]
//   heap_size_i  heap_module.heap_size
//   count        scheduler occupancy, 0..DEPTH
//   sync_err     sticky flag, heap size disagreed with count while idle
//
// Configuration macro:
//   HEAP_SCHED_POP_PRIO_EN - when defined, pending pops win arbitration over
//   pending pushes; round-robin then applies among the pop requesters only.
// ============================================================================
module heap_op_scheduler #(
    parameter int NREQ   = 2,
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_op,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [2:0]         rsp_id,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               heap_enable,
    output logic [4:0]         heap_op,
    output logic [DW-1:0]      heap_din,
    input  logic [DW-1:0]      heap_top,
    input  logic [4:0]         heap_size_i,
    output logic [5:0]         count,
    output logic               sync_err
);

    localparam logic [4:0] OP_INIT  = 5'd0;
    localparam logic [4:0] OP_PUSH  = 5'd1;
    localparam logic [4:0] OP_POP   = 5'd2;
    localparam logic [5:0] DEPTH_C  = 6'(DEPTH);
    localparam logic [2:0] LAST_REQ = 3'(NREQ - 1);
    localparam int         WW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      rr_ptr;
    logic [2:0]      cur_id;
    logic            cur_op;
    logic [DW-1:0]   cur_data;
    logic            cur_err;
    logic [DW-1:0]   result;
    logic [WW-1:0]   wait_cnt;

    logic [NREQ-1:0] cand;
    logic [7:0]      cand8;
    logic [7:0]      op8;
    logic [3:0]      arb_sum;
    logic            grant_any;
    logic [2:0]      grant_idx;
    logic [NREQ-1:0] grant;
    logic            grant_op;
    logic [DW-1:0]   grant_data;
    logic            acc_err;

    // Arbitration: search starts one past the last winner and wraps modulo
    // NREQ. The candidate set is widened to 8 bits so any requester index can
    // address it directly. With pop priority enabled the candidate set shrinks
    // to the pop requesters whenever at least one pop is pending.
    always_comb begin
        cand = req_valid;
`ifdef HEAP_SCHED_POP_PRIO_EN
        if (|(req_valid & req_op)) begin
            cand = req_valid & req_op;
        end
`endif
        cand8     = 8'(cand);
        op8       = 8'(req_op);
        arb_sum   = 4'd0;
        grant_any = 1'b0;
        grant_idx = 3'd0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_sum = {1'b0, rr_ptr} + 4'(i);
            if (arb_sum >= 4'(NREQ)) begin
                arb_sum = arb_sum - 4'(NREQ);
            end
            if (!grant_any && cand8[arb_sum[2:0]]) begin
                grant_any = 1'b1;
                grant_idx = arb_sum[2:0];
            end
        end
        grant      = grant_any ? (NREQ'(1) << grant_idx) : '0;
        grant_op   = op8[grant_idx];
        grant_data = req_data[grant_idx*DW +: DW];
        acc_err    = grant_op ? (count == 6'd0) : (count == DEPTH_C);
    end

    // Next-state and output decode. The INIT command is held off while reset
    // is asserted so that every output reads 0 during reset.
    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        heap_enable = 1'b0;
        heap_op     = OP_INIT;
        heap_din    = '0;
        rsp_valid   = 1'b0;
        rsp_id      = 3'd0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        case (state)
            S_INIT: begin
                heap_enable = ~reset;
                state_nxt   = S_IDLE;
            end
            S_IDLE: begin
                req_ready = grant;
                if (grant_any) begin
                    state_nxt = acc_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                heap_enable = 1'b1;
                heap_op     = cur_op ? OP_POP : OP_PUSH;
                heap_din    = cur_op ? '0 : cur_data;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = cur_id;
                rsp_data  = result;
                rsp_err   = cur_err;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State register plus the request latch, occupancy count and settle timer.
    // The pop result is taken from heap_top during ISSUE, before the heap
    // applies the pop on the closing edge of that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            rr_ptr   <= LAST_REQ;
            cur_id   <= 3'd0;
            cur_op   <= 1'b0;
            cur_data <= '0;
            cur_err  <= 1'b0;
            result   <= '0;
            wait_cnt <= '0;
            count    <= 6'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_INIT: begin
                    count <= 6'd0;
                end
                S_IDLE: begin
                    if (grant_any) begin
                        rr_ptr   <= grant_idx;
                        cur_id   <= grant_idx;
                        cur_op   <= grant_op;
                        cur_data <= grant_data;
                        cur_err  <= acc_err;
                        result   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (cur_op) begin
                        result <= heap_top;
                        count  <= count - 6'd1;
                    end else begin
                        count  <= count + 6'd1;
                    end
                    wait_cnt <= WW'(SETTLE - 1);
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Consistency monitor: only while idle is the heap guaranteed to have
    // absorbed the last command, so that is the only time sizes are compared.
    // At count == 32 both 5-bit views wrap to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err <= 1'b0;
        end else if (state == S_IDLE && heap_size_i != count[4:0]) begin
            sync_err <= 1'b1;
        end
    end

endmodule
